// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generator with return-address-stack prediction
//
// Purpose: holds the fetch PC and selects the next value by priority
//   trap > redirect > stall > RAS return > sequential.
// Ports:
//   clk             in   rising-edge clock
//   rst             in   asynchronous active-low reset
//   stall           in   hold PC, pc_src and RAS this cycle
//   redirect_valid  in   resolved branch/jump correction
//   redirect_target in   redirect destination (bits[1:0] ignored)
//   trap_valid      in   trap entry / mret
//   trap_vector     in   trap destination (bits[1:0] ignored)
//   call            in   instruction at pc_out is a call
//   ret             in   instruction at pc_out is a return
//   pc_out          out  registered fetch PC
//   pc_plus4        out  pc_out + 4
//   pc_src          out  0 seq, 1 RAS, 2 redirect, 3 trap/reset
//   ras_empty       out  RAS holds no entries
//   ras_full        out  RAS holds RAS_DEPTH entries
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic [1:0]      pc_src,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      src_q, src_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  logic            ras_we;
  logic [PW-1:0]   ras_waddr;
  logic            ras_hit;

  assign pc_out    = pc_q;
  assign pc_src    = src_q;
  assign pc_plus4  = pc_q + XLEN'(4);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_FULL);

  always_comb begin
    pc_d      = pc_q;
    src_d     = src_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ras_we    = 1'b0;
    ras_waddr = ptr_q;
    ras_hit   = ret && !ras_empty;

    if (trap_valid) begin
      pc_d  = {trap_vector[XLEN-1:2], 2'b00};
      src_d = 2'd3;
      cnt_d = '0;
    end else if (redirect_valid) begin
      pc_d  = {redirect_target[XLEN-1:2], 2'b00};
      src_d = 2'd2;
    end else if (!stall) begin
      if (ras_hit) begin
        pc_d  = ras_q[ptr_q];
        src_d = 2'd1;
      end else begin
        pc_d  = pc_plus4;
        src_d = 2'd0;
      end

      if (call && ras_hit) begin
        // Return-then-call: replace the entry just consumed, depth unchanged.
        ras_we = 1'b1;
      end else if (call) begin
        // Circular push; when full this overwrites the oldest entry.
        ras_we    = 1'b1;
        ptr_d     = ptr_q + PW'(1);
        ras_waddr = ptr_q + PW'(1);
        if (!ras_full) cnt_d = cnt_q + CW'(1);
      end else if (ras_hit) begin
        ptr_d = ptr_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= RESET_VECTOR;
      src_q <= 2'd3;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      src_q <= src_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Return-address storage is deliberately not reset; count gates its use.
  always_ff @(posedge clk) begin
    if (ras_we) ras_q[ras_waddr] <= pc_plus4;
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen against a queue-based reference model
module tb_pc_gen;

  localparam logic [31:0] RV    = 32'h0000_1000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_vector = '0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [1:0]  pc_src;
  logic        ras_empty;
  logic        ras_full;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a PC, its source, and the RAS as a bounded list of return addresses.
  logic [31:0] m_pc  = RV;
  logic [1:0]  m_src = 2'd3;
  logic [31:0] m_ras [$];

  pc_gen #(
    .XLEN         (32),
    .RESET_VECTOR (RV),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .call            (call),
    .ret             (ret),
    .pc_out          (pc_out),
    .pc_plus4        (pc_plus4),
    .pc_src          (pc_src),
    .ras_empty       (ras_empty),
    .ras_full        (ras_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = RV;
    m_src = 2'd3;
    m_ras.delete();
  endtask

  task automatic model_step(input logic t, input logic [31:0] tv, input logic r,
                            input logic [31:0] rt, input logic s, input logic c,
                            input logic rr);
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (t) begin
      m_pc  = tv & ~32'd3;
      m_src = 2'd3;
      m_ras.delete();
    end else if (r) begin
      m_pc  = rt & ~32'd3;
      m_src = 2'd2;
    end else if (!s) begin
      if (rr && m_ras.size() > 0) begin
        m_pc  = m_ras[m_ras.size()-1];
        m_src = 2'd1;
        if (c) m_ras[m_ras.size()-1] = seq;
        else   void'(m_ras.pop_back());
      end else begin
        m_pc  = seq;
        m_src = 2'd0;
        if (c) begin
          m_ras.push_back(seq);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pc"},    pc_out,             m_pc);
    check({tag, ".src"},   {30'd0, pc_src},    {30'd0, m_src});
    check({tag, ".p4"},    pc_plus4,           m_pc + 32'd4);
    check({tag, ".empty"}, {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
    check({tag, ".full"},  {31'd0, ras_full},  {31'd0, m_ras.size() == DEPTH});
  endtask

  // Called at a negedge: drive inputs, advance one rising edge, compare at the next negedge.
  task automatic tick(input string tag, input logic t, input logic [31:0] tv, input logic r,
                      input logic [31:0] rt, input logic s, input logic c, input logic rr);
    trap_valid      = t;
    trap_vector     = tv;
    redirect_valid  = r;
    redirect_target = rt;
    stall           = s;
    call            = c;
    ret             = rr;
    model_step(t, tv, r, rt, s, c, rr);
    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic seq_tick(input string tag);
    tick(tag, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic redir(input string tag, input logic [31:0] a);
    tick(tag, 1'b0, 32'd0, 1'b1, a, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset held for two cycles
    @(negedge clk);
    @(negedge clk);
    model_reset();
    compare_all("reset");
    check("reset_pc", pc_out, 32'h0000_1000);
    rst = 1'b1;

    // Sequential after release
    seq_tick("seq1");
    check("seq1_pc", pc_out, 32'h0000_1004);
    seq_tick("seq2");
    seq_tick("seq3");
    check("seq3_pc", pc_out, 32'h0000_100C);

    // Stall, then stall with redirect
    tick("stall1", 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    tick("stall2", 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    check("stall_pc", pc_out, 32'h0000_100C);
    tick("stredir", 1'b0, 32'd0, 1'b1, 32'hAAAA_BBBB, 1'b1, 1'b0, 1'b0);
    check("redir_pc", pc_out, 32'hAAAA_BBB8);

    // Call then return
    redir("to2000", 32'h2000);
    tick("call", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    redir("to3000", 32'h3000);
    tick("ret", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    check("ret_pc", pc_out, 32'h0000_2004);
    check("ret_src", {30'd0, pc_src}, 32'd1);

    // Overflow: five calls into a depth-4 stack, then five returns
    for (int i = 1; i <= 5; i++) begin
      redir("ovf_redir", 32'(i * 32'h100));
      tick("ovf_call", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    end
    check("ovf_full", {31'd0, ras_full}, 32'd1);
    for (int i = 0; i < 5; i++) tick("ovf_ret", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    check("ovf_last_pc", pc_out, 32'h0000_0208);
    check("ovf_last_src", {30'd0, pc_src}, 32'd0);

    // Call+ret together: empty then non-empty
    tick("cr_empty", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    tick("cr_full", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    tick("cr_pop", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

    // Trap beats redirect and ret, and flushes the RAS
    tick("pre_trap", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    tick("trap", 1'b1, 32'hCAFE_BABE, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    check("trap_pc", pc_out, 32'hCAFE_BABC);
    check("trap_empty", {31'd0, ras_empty}, 32'd1);

    // Wrap at the top of the address space
    redir("to_top", 32'hFFFF_FFFC);
    seq_tick("wrap");
    check("wrap_pc", pc_out, 32'h0000_0000);

    // Asynchronous reset between edges
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("arst_pc", pc_out, RV);
    check("arst_src", {30'd0, pc_src}, 32'd3);
    check("arst_empty", {31'd0, ras_empty}, 32'd1);
    @(negedge clk);
    compare_all("arst_hold");
    rst = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic t, r, s, c, rr;
      t  = ($urandom_range(0, 31) == 0);
      r  = ($urandom_range(0, 7) == 0);
      s  = ($urandom_range(0, 5) == 0);
      c  = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 3) == 0);
      tick("rand", t, $urandom, r, $urandom, s, c, rr);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
